elevator_car_ctrl: RTL
======================

Name: elevator_car_ctrl

Overview:
- Sequential car controller directly downstream of the 11-floor high-priority call encoder.
- Consumes the encoder's 4-bit code and valid flag, moves the car one floor at a time with a travel timer, and opens the door at the target floor.
- Issues a one-cycle one-hot "served" pulse so the upstream call latch can clear the serviced floor.

Parameters:
- NUM_FLOORS, 11, floor count; floors are 0..NUM_FLOORS-1.
- TRAVEL_CYCLES, 8, clock cycles to travel one floor (>=2).
- DOOR_CYCLES, 16, clock cycles the door stays open (>=2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_code  input  4  encoder code; code c selects target floor 10-c; codes 11..15 are invalid.
- req_valid  input  1  encoder V: at least one call pending.
- door_hold  input  1  door-open button; level-sensitive.
- cur_floor  output  4  current car floor.
- dir_up  output  1  car moving up.
- dir_dn  output  1  car moving down.
- door_open  output  1  door open.
- served  output  11  one-hot floor-served pulse, one cycle wide.
- bad_code  output  1  one-cycle pulse: req_valid with code 11..15 was sampled.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n). All state is on the clk rising edge.
- Reset values: state IDLE, cur_floor 0, dir_up 0, dir_dn 0, door_open 0, served 0, bad_code 0, timers 0. Reset mid-move or mid-door returns to these values immediately. After reset the car is assumed at floor 0.
- Target decode:
  - tgt = 10 - req_code.
  - A request is usable only if req_valid=1 and req_code<=10.
  - If req_valid=1 and req_code>10: bad_code pulses that cycle and the input is treated as no request.
- States: IDLE, MOVE_UP, MOVE_DN, DOOR.
- IDLE:
  - No usable request: stay in IDLE.
  - tgt==cur_floor: go to DOOR next cycle.
  - tgt>cur_floor: go to MOVE_UP.
  - tgt<cur_floor: go to MOVE_DN.
  - Decision latency is 1 cycle.
- MOVE_UP / MOVE_DN:
  - dir_up or dir_dn is 1 for the whole state (never both).
  - Travel timer counts 0..TRAVEL_CYCLES-1. On the terminal count, cur_floor increments (up) or decrements (down) and the timer clears.
  - On that same edge the live request is re-evaluated against the new floor:
    - tgt equals the new floor: go to DOOR.
    - No usable request: go to IDLE, car stops at the new floor.
    - tgt still ahead in the current direction: continue.
    - tgt behind: go to IDLE; IDLE re-decides next cycle. No direct reversal.
  - Request changes between floor boundaries are ignored; the target is sampled only at boundaries.
  - cur_floor is saturated to 0..NUM_FLOORS-1. It must never wrap, even with a corrupt input.
- DOOR:
  - On entry, served[cur_floor] pulses for exactly one cycle; this is the first cycle door_open=1.
  - door_open=1 for DOOR_CYCLES cycles; the door timer counts 0..DOOR_CYCLES-1.
  - door_hold=1 clears the door timer each cycle it is high. The door stays open while held plus DOOR_CYCLES after release.
  - On terminal count with door_hold=0: go to IDLE and door_open falls.
  - No movement while door_open=1.
- Simultaneous events:
  - A request for the current floor arriving while in DOOR does not re-pulse served; it is handled from IDLE afterwards.
  - The upstream latch is responsible for clearing the call on served. If the call is still asserted when IDLE is reached, the door re-opens and served pulses again; this is the specified behaviour.
- served and bad_code are registered outputs.

Test Plan:
- Reset, then req_valid=1, req_code=7 (floor 3) held:
  - MOVE_UP entered 1 cycle later.
  - cur_floor steps to 1, 2, 3 at +8, +16, +24 cycles after MOVE_UP entry.
  - served=11'b00000001000 pulses once at floor 3; door_open high 16 cycles; then IDLE.
- Car at floor 3 idle, req_code=9 (floor 1):
  - dir_dn=1, floor goes 2 then 1, door opens.
  - Also drop req_valid mid-travel: car stops at the next boundary floor, goes to IDLE, door stays closed.
- While moving up from 0 toward floor 5 (code 5):
  - Between boundaries switch to code 8 (floor 2): the change is ignored until the next boundary.
  - If the boundary lands on floor 2: stop, door, served bit 2.
  - If floor 2 is already behind the car: IDLE, then MOVE_DN.
- Request at current floor (car at 0, code 10):
  - DOOR the next cycle, served bit 0.
  - door_hold held 20 cycles then released: door_open lasts 20+16 cycles total.
- req_valid=1, req_code=13: bad_code pulses every sampled cycle, car stays IDLE, no served.
- Assert rst_n=0 mid-MOVE_UP at floor 4 and mid-DOOR: all outputs return to their reset values asynchronously, before the next clk edge.

Source files
------------

// File: rtl/elevator_car_ctrl_if.sv
// Request/status bundle between the call encoder side and the elevator car controller.
// The master drives the encoded request and the door button; the slave (car) reports position and door state.
interface elevator_car_ctrl_if #(
    parameter int unsigned NUM_FLOORS = 11
);
    logic [3:0]            req_code;
    logic                  req_valid;
    logic                  door_hold;
    logic [3:0]            cur_floor;
    logic                  dir_up;
    logic                  dir_dn;
    logic                  door_open;
    logic [NUM_FLOORS-1:0] served;
    logic                  bad_code;

    modport master (
        output req_code, req_valid, door_hold,
        input  cur_floor, dir_up, dir_dn, door_open, served, bad_code
    );

    modport slave (
        input  req_code, req_valid, door_hold,
        output cur_floor, dir_up, dir_dn, door_open, served, bad_code
    );
endinterface

// File: rtl/elevator_car_ctrl.sv
// Elevator car controller: moves one floor per travel period toward the encoded target,
// opens the door on arrival, and pulses a one-hot served flag for the upstream call latch.
module elevator_car_ctrl #(
    parameter int unsigned NUM_FLOORS    = 11,
    parameter int unsigned TRAVEL_CYCLES = 8,
    parameter int unsigned DOOR_CYCLES   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    elevator_car_ctrl_if.slave  bus
);
    localparam int unsigned FW = 4;
    localparam int unsigned CW = 4;
    localparam int unsigned TW = $clog2(TRAVEL_CYCLES);
    localparam int unsigned DW = $clog2(DOOR_CYCLES);
    localparam logic [FW-1:0] TOP_FLOOR = FW'(NUM_FLOORS - 1);
    localparam logic [CW-1:0] MAX_CODE  = CW'(NUM_FLOORS - 1);
    localparam logic [TW-1:0] TRAV_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DN, DOOR} state_t;

    state_t                state, state_nxt;
    logic [FW-1:0]         floor_q, floor_nxt;
    logic [TW-1:0]         trav_q, trav_nxt;
    logic [DW-1:0]         door_q, door_nxt;
    logic                  dir_up_q, dir_dn_q, door_open_q, bad_code_q;
    logic [NUM_FLOORS-1:0] served_q, served_nxt;

    logic                  usable, bad_req;
    logic [FW-1:0]         tgt, step_up, step_dn;

    // Target decode: code c selects floor (NUM_FLOORS-1)-c; out-of-range codes are no request.
    always_comb begin
        usable  = bus.req_valid && (bus.req_code <= MAX_CODE);
        bad_req = bus.req_valid && (bus.req_code > MAX_CODE);
        tgt     = usable ? FW'(MAX_CODE - bus.req_code) : '0;
    end

    // Saturating floor steps; a corrupt floor value is pulled back into range.
    always_comb begin
        step_up = (floor_q >= TOP_FLOOR) ? TOP_FLOOR : FW'(floor_q + 1'b1);
        if (floor_q == '0)
            step_dn = '0;
        else if (floor_q > TOP_FLOOR)
            step_dn = TOP_FLOOR;
        else
            step_dn = FW'(floor_q - 1'b1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            floor_q     <= '0;
            trav_q      <= '0;
            door_q      <= '0;
            dir_up_q    <= 1'b0;
            dir_dn_q    <= 1'b0;
            door_open_q <= 1'b0;
            served_q    <= '0;
            bad_code_q  <= 1'b0;
        end else begin
            state       <= state_nxt;
            floor_q     <= floor_nxt;
            trav_q      <= trav_nxt;
            door_q      <= door_nxt;
            dir_up_q    <= (state_nxt == MOVE_UP);
            dir_dn_q    <= (state_nxt == MOVE_DN);
            door_open_q <= (state_nxt == DOOR);
            served_q    <= served_nxt;
            bad_code_q  <= bad_req;
        end
    end

    // Next state; the target is only looked at in IDLE and on floor boundaries.
    always_comb begin
        state_nxt  = state;
        floor_nxt  = floor_q;
        trav_nxt   = '0;
        door_nxt   = '0;
        served_nxt = '0;
        case (state)
            IDLE: begin
                if (usable) begin
                    if (tgt == floor_q)
                        state_nxt = DOOR;
                    else if (tgt > floor_q)
                        state_nxt = MOVE_UP;
                    else
                        state_nxt = MOVE_DN;
                end
            end
            MOVE_UP: begin
                if (trav_q == TRAV_LAST) begin
                    floor_nxt = step_up;
                    if (!usable)
                        state_nxt = IDLE;
                    else if (tgt == step_up)
                        state_nxt = DOOR;
                    else if (tgt > step_up)
                        state_nxt = MOVE_UP;
                    else
                        state_nxt = IDLE;
                end else begin
                    trav_nxt = TW'(trav_q + 1'b1);
                end
            end
            MOVE_DN: begin
                if (trav_q == TRAV_LAST) begin
                    floor_nxt = step_dn;
                    if (!usable)
                        state_nxt = IDLE;
                    else if (tgt == step_dn)
                        state_nxt = DOOR;
                    else if (tgt < step_dn)
                        state_nxt = MOVE_DN;
                    else
                        state_nxt = IDLE;
                end else begin
                    trav_nxt = TW'(trav_q + 1'b1);
                end
            end
            DOOR: begin
                // Holding the button restarts the open period every cycle it is pressed.
                if (bus.door_hold)
                    door_nxt = '0;
                else if (door_q == DOOR_LAST)
                    state_nxt = IDLE;
                else
                    door_nxt = DW'(door_q + 1'b1);
            end
            default: state_nxt = IDLE;
        endcase

        // Served fires once, in the first cycle the door is open.
        if ((state_nxt == DOOR) && (state != DOOR))
            served_nxt = NUM_FLOORS'(1) << floor_nxt;
    end

    assign bus.cur_floor = floor_q;
    assign bus.dir_up    = dir_up_q;
    assign bus.dir_dn    = dir_dn_q;
    assign bus.door_open = door_open_q;
    assign bus.served    = served_q;
    assign bus.bad_code  = bad_code_q;
endmodule
